// File: rtl/zap_mem_arbiter_pkg.sv
// zap_mem_arbiter_pkg: owner encodings and response tag layout shared by the arbiter and its tag pipeline
package zap_mem_arbiter_pkg;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  typedef struct packed {
    logic valid;
    logic owner;
    logic wr;
    logic abort;
  } tag_t;
endpackage

// File: rtl/zap_mem_arb_tagpipe.sv
// zap_mem_arb_tagpipe: MEM_LATENCY-deep tag shift register with sync clear; i_tag enters, o_tag is the last stage
module zap_mem_arb_tagpipe
  import zap_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  tag_t i_tag,
  output tag_t o_tag
);
  tag_t [MEM_LATENCY-1:0] r_stage;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_stage <= '0;
    else begin
      r_stage[0] <= i_tag;
      for (int k = 1; k < MEM_LATENCY; k++) r_stage[k] <= r_stage[k-1];
    end
  end
  assign o_tag = r_stage[MEM_LATENCY-1];
endmodule

// File: rtl/zap_mem_arbiter.sv
// zap_mem_arbiter: shares one single-port sync RAM between the ZAP fetch port (i_ireq/o_code_*) and data port (i_read_en/i_write_en/o_data_*), driving o_mem_* and taking i_mem_rdata
module zap_mem_arbiter
  import zap_mem_arbiter_pkg::*;
#(
  parameter int RAM_SIZE    = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ireq,
  input  logic [31:0] i_iaddress,
  output logic [31:0] o_idata,
  output logic        o_code_hit,
  output logic        o_code_abort,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_daddress,
  input  logic [3:0]  i_ben,
  input  logic [31:0] i_ddata,
  output logic [31:0] o_ddata,
  output logic        o_data_stall,
  output logic        o_data_abort,
  output logic        o_mem_en,
  output logic        o_mem_wr,
  output logic [29:0] o_mem_addr,
  output logic [3:0]  o_mem_ben,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);
  logic        r_i_pend, r_d_pend;
  logic        w_dreq, w_gnt_d, w_gnt_i, w_gnt, w_wr, w_oor, w_resp_i, w_resp_d;
  logic [31:0] w_addr;
  tag_t        w_tag_in, w_tag_out;
  assign w_dreq   = i_read_en | i_write_en;
  // pending flags stay set through the response cycle so the still-presented request is not re-granted
  assign w_gnt_d  = !i_reset & w_dreq & !r_d_pend;
  assign w_gnt_i  = !i_reset & !w_gnt_d & i_ireq & !r_i_pend;
  assign w_gnt    = w_gnt_d | w_gnt_i;
  assign w_addr   = w_gnt_d ? i_daddress : i_iaddress;
  assign w_oor    = w_addr > 32'(RAM_SIZE - 4);
  assign w_wr     = w_gnt_d & i_write_en;
  assign w_tag_in = '{valid: w_gnt, owner: (w_gnt_d ? OWN_D : OWN_I), wr: w_wr, abort: w_oor};
  zap_mem_arb_tagpipe #(.MEM_LATENCY(MEM_LATENCY)) u_tagpipe (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );
  assign w_resp_i     = !i_reset & w_tag_out.valid & (w_tag_out.owner == OWN_I);
  assign w_resp_d     = !i_reset & w_tag_out.valid & (w_tag_out.owner == OWN_D);
  assign o_code_hit   = w_resp_i & !w_tag_out.abort;
  assign o_code_abort = w_resp_i & w_tag_out.abort;
  assign o_idata      = o_code_hit ? i_mem_rdata : '0;
  assign o_data_abort = w_resp_d & w_tag_out.abort;
  assign o_ddata      = (w_resp_d & !w_tag_out.abort & !w_tag_out.wr) ? i_mem_rdata : '0;
  assign o_data_stall = w_dreq & !w_resp_d;
  assign o_mem_en     = w_gnt & !w_oor;
  assign o_mem_wr     = o_mem_en & w_wr;
  assign o_mem_addr   = o_mem_en ? w_addr[31:2] : '0;
  assign o_mem_ben    = o_mem_wr ? i_ben : o_mem_en ? 4'hF : 4'h0;
  assign o_mem_wdata  = o_mem_wr ? i_ddata : '0;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_i_pend <= 1'b0;
      r_d_pend <= 1'b0;
    end else begin
      r_i_pend <= w_gnt_i | (r_i_pend & !w_resp_i);
      r_d_pend <= w_gnt_d | (r_d_pend & !w_resp_d);
    end
  end
endmodule

// File: tb/tb_zap_mem_arbiter.sv
// tb_zap_mem_arbiter: directed checks of zap_mem_arbiter at MEM_LATENCY 1 (u_a) and 3 (u_b) against behavioural RAMs
module tb_zap_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail  = 0;
  logic        a_rst, a_ireq, a_hit, a_cab, a_rd, a_wr, a_stall, a_dab, a_men, a_mwr;
  logic [31:0] a_iaddr, a_idata, a_daddr, a_wdat, a_ddata, a_mwdata, a_rdata;
  logic [3:0]  a_ben, a_mben;
  logic [29:0] a_maddr;
  logic        b_rst, b_ireq, b_hit, b_cab, b_rd, b_wr, b_stall, b_dab, b_men, b_mwr;
  logic [31:0] b_iaddr, b_idata, b_daddr, b_wdat, b_ddata, b_mwdata, b_rdata;
  logic [3:0]  b_ben, b_mben;
  logic [29:0] b_maddr;
  zap_mem_arbiter #(.RAM_SIZE(1024), .MEM_LATENCY(1)) u_a (
    .i_clk(clk), .i_reset(a_rst), .i_ireq(a_ireq), .i_iaddress(a_iaddr), .o_idata(a_idata),
    .o_code_hit(a_hit), .o_code_abort(a_cab), .i_read_en(a_rd), .i_write_en(a_wr),
    .i_daddress(a_daddr), .i_ben(a_ben), .i_ddata(a_wdat), .o_ddata(a_ddata),
    .o_data_stall(a_stall), .o_data_abort(a_dab), .o_mem_en(a_men), .o_mem_wr(a_mwr),
    .o_mem_addr(a_maddr), .o_mem_ben(a_mben), .o_mem_wdata(a_mwdata), .i_mem_rdata(a_rdata)
  );
  zap_mem_arbiter #(.RAM_SIZE(1024), .MEM_LATENCY(3)) u_b (
    .i_clk(clk), .i_reset(b_rst), .i_ireq(b_ireq), .i_iaddress(b_iaddr), .o_idata(b_idata),
    .o_code_hit(b_hit), .o_code_abort(b_cab), .i_read_en(b_rd), .i_write_en(b_wr),
    .i_daddress(b_daddr), .i_ben(b_ben), .i_ddata(b_wdat), .o_ddata(b_ddata),
    .o_data_stall(b_stall), .o_data_abort(b_dab), .o_mem_en(b_men), .o_mem_wr(b_mwr),
    .o_mem_addr(b_maddr), .o_mem_ben(b_mben), .o_mem_wdata(b_mwdata), .i_mem_rdata(b_rdata)
  );
  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    a_rdata <= (a_men & !a_mwr) ? ram_a[a_maddr[7:0]] : 32'h0;
    if (a_men & a_mwr)
      for (int k = 0; k < 4; k++) if (a_mben[k]) ram_a[a_maddr[7:0]][8*k+:8] <= a_mwdata[8*k+:8];
  end
  always @(posedge clk) begin
    pipe_b[0] <= (b_men & !b_mwr) ? ram_b[b_maddr[7:0]] : 32'h0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (b_men & b_mwr)
      for (int k = 0; k < 4; k++) if (b_mben[k]) ram_b[b_maddr[7:0]][8*k+:8] <= b_mwdata[8*k+:8];
  end
  assign b_rdata = pipe_b[2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic a_store(input logic [31:0] addr, input logic [31:0] data);
    a_wr = 1'b1; a_daddr = addr; a_wdat = data; a_ben = 4'hF;
    tick; tick;
    a_wr = 1'b0;
  endtask
  task automatic b_store(input logic [31:0] addr, input logic [31:0] data);
    b_wr = 1'b1; b_daddr = addr; b_wdat = data; b_ben = 4'hF;
    tick; tick; tick; tick;
    b_wr = 1'b0;
  endtask
  logic        t_en    [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
  logic [31:0] t_addr  [9] = '{32'h40, 32'h0, 0, 0, 32'h41, 32'h1, 0, 0, 0};
  logic        t_hit   [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  logic [31:0] t_idata [9] = '{0, 0, 0, 0, 32'hB0, 0, 0, 0, 32'hB1};
  logic        t_stall [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
  logic [31:0] t_ddata [9] = '{0, 0, 0, 32'hA0, 0, 0, 0, 32'hA1, 0};
  initial begin
    a_rst = 1; a_ireq = 0; a_iaddr = 0; a_rd = 1; a_wr = 0; a_daddr = 0; a_ben = 0; a_wdat = 0;
    b_rst = 1; b_ireq = 0; b_iaddr = 0; b_rd = 0; b_wr = 0; b_daddr = 0; b_ben = 0; b_wdat = 0;
    tick; tick;
    mid;
    chk("rst_stall_follows_req", a_stall, 1);
    chk("rst_mem_en", a_men, 0);
    chk("rst_outs_a", {a_hit, a_cab, a_dab, a_mwr, a_mben}, 0);
    chk("rst_data_a", a_ddata | a_idata | a_mwdata | 32'(a_maddr), 0);
    chk("rst_outs_b", {b_hit, b_cab, b_dab, b_stall, b_men}, 0);
    tick;
    a_rd = 0;
    mid;
    chk("rst_stall_idle", a_stall, 0);
    tick;
    a_rst = 0; b_rst = 0;
    a_store(32'h10, 32'hE3A00001);
    a_store(32'h40, 32'h11223344);
    a_store(32'h20, 32'hCAFEF00D);
    a_store(32'h00, 32'hDEADBEEF);
    a_ireq = 1; a_iaddr = 32'h10;
    mid;
    chk("t1_mem_en", a_men, 1);
    chk("t1_mem_addr", 32'(a_maddr), 32'h4);
    chk("t1_mem_rd", a_mwr, 0);
    chk("t1_no_hit_yet", a_hit, 0);
    tick; mid;
    chk("t1_hit", a_hit, 1);
    chk("t1_idata", a_idata, 32'hE3A00001);
    chk("t1_no_regrant", a_men, 0);
    tick;
    a_ireq = 0;
    mid;
    chk("t1_hit_one_cycle", a_hit, 0);
    chk("t1_idata_zero", a_idata, 0);
    tick;
    a_ireq = 1; a_iaddr = 32'h0; a_rd = 1; a_daddr = 32'h20;
    mid;
    chk("t2_data_first", 32'(a_maddr), 32'h8);
    chk("t2_en_n", a_men, 1);
    chk("t2_stall_n", a_stall, 1);
    tick; mid;
    chk("t2_fetch_n1_en", a_men, 1);
    chk("t2_fetch_n1_addr", 32'(a_maddr), 32'h0);
    chk("t2_stall_n1", a_stall, 0);
    chk("t2_ddata", a_ddata, 32'hCAFEF00D);
    tick;
    a_rd = 0;
    mid;
    chk("t2_hit_n2", a_hit, 1);
    chk("t2_idata", a_idata, 32'hDEADBEEF);
    chk("t2_no_regrant", a_men, 0);
    tick;
    a_ireq = 0;
    a_wr = 1; a_daddr = 32'h40; a_ben = 4'b0010; a_wdat = 32'h0000AB00;
    mid;
    chk("t3_mem_wr", a_mwr, 1);
    chk("t3_mem_ben", 32'(a_mben), 32'h2);
    chk("t3_mem_wdata", a_mwdata, 32'h0000AB00);
    chk("t3_stall_n", a_stall, 1);
    tick; mid;
    chk("t3_stall_n1", a_stall, 0);
    chk("t3_wr_no_ddata", a_ddata, 0);
    tick;
    a_wr = 0; a_rd = 1;
    mid;
    chk("t3_rd_ben", 32'(a_mben), 32'hF);
    chk("t3_rd_en", {a_men, a_mwr}, 2'b10);
    tick; mid;
    chk("t3_readback", a_ddata, 32'h1122AB44);
    tick;
    a_daddr = 32'h400;
    mid;
    chk("t4_oor_no_en", a_men, 0);
    chk("t4_oor_stall", a_stall, 1);
    tick; mid;
    chk("t4_abort", a_dab, 1);
    chk("t4_abort_ddata", a_ddata, 0);
    chk("t4_abort_stall", a_stall, 0);
    tick;
    a_daddr = 32'h3FC;
    mid;
    chk("t4_edge_en", a_men, 1);
    chk("t4_edge_addr", 32'(a_maddr), 32'hFF);
    tick; mid;
    chk("t4_edge_no_abort", a_dab, 0);
    tick;
    a_daddr = 32'hFFFFFFFC;
    mid;
    chk("t4_hi_no_en", a_men, 0);
    tick; mid;
    chk("t4_hi_abort", a_dab, 1);
    tick;
    a_rd = 0; a_ireq = 1; a_iaddr = 32'h1000;
    mid;
    chk("t4_fetch_oor_no_en", a_men, 0);
    tick; mid;
    chk("t4_code_abort", {a_cab, a_hit}, 2'b10);
    chk("t4_code_abort_idata", a_idata, 0);
    tick;
    a_ireq = 0;
    b_store(32'h100, 32'hA0);
    b_store(32'h104, 32'hA1);
    b_store(32'h000, 32'hB0);
    b_store(32'h004, 32'hB1);
    for (int c = 0; c < 9; c++) begin
      b_rd = c < 8; b_daddr = c < 4 ? 32'h100 : 32'h104;
      b_ireq = 1; b_iaddr = c < 5 ? 32'h0 : 32'h4;
      mid;
      chk($sformatf("t5_en_c%0d", c), b_men, t_en[c]);
      chk($sformatf("t5_addr_c%0d", c), 32'(b_maddr), t_addr[c]);
      chk($sformatf("t5_hit_c%0d", c), b_hit, t_hit[c]);
      chk($sformatf("t5_idata_c%0d", c), b_idata, t_idata[c]);
      chk($sformatf("t5_stall_c%0d", c), b_stall, t_stall[c]);
      chk($sformatf("t5_ddata_c%0d", c), b_ddata, t_ddata[c]);
      tick;
    end
    b_ireq = 0; b_rd = 0;
    tick;
    b_rd = 1; b_daddr = 32'h100;
    mid;
    chk("t6_grant", b_men, 1);
    tick;
    b_rst = 1; b_rd = 0;
    mid;
    chk("t6_rst_cycle", {b_dab, b_hit, b_stall, b_men}, 0);
    chk("t6_rst_ddata", b_ddata, 0);
    tick;
    b_rst = 0;
    for (int c = 0; c < 3; c++) begin
      mid;
      chk($sformatf("t6_quiet_c%0d", c), {b_dab, b_hit, b_cab, b_stall, b_men, b_mwr}, 0);
      chk($sformatf("t6_ddata_c%0d", c), b_ddata, 0);
      tick;
    end
    b_rd = 1; b_daddr = 32'h104;
    mid;
    chk("t6_regrant_addr", {b_men, 32'(b_maddr)}, {1'b1, 32'h41});
    tick; tick; tick; mid;
    chk("t6_after_rst_ddata", b_ddata, 32'hA1);
    tick;
    b_rd = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
